// File: rtl/mem_port_arbiter_if.sv
// Memory-port arbiter bus: fetch and data request/response channels, the
// shared memory port, and the arbiter status outputs.
// slave  = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic              if_req_valid;
   logic [ADDR_W-1:0] if_req_addr;
   logic              if_req_ready;
   logic              if_rsp_valid;
   logic [DATA_W-1:0] if_rsp_data;

   logic              d_req_valid;
   logic              d_req_we;
   logic [ADDR_W-1:0] d_req_addr;
   logic [DATA_W-1:0] d_req_wdata;
   logic [BE_W-1:0]   d_req_be;
   logic              d_req_ready;
   logic              d_rsp_valid;
   logic [DATA_W-1:0] d_rsp_data;

   logic              mem_en;
   logic              mem_we;
   logic [BE_W-1:0]   mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              owner;
   logic [1:0]        state_vector;
   logic              err_misaligned;

   modport slave (
      input  if_req_valid, if_req_addr,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_be,
      output d_req_ready, d_rsp_valid, d_rsp_data,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata,
      output owner, state_vector, err_misaligned
   );

   modport master (
      output if_req_valid, if_req_addr,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_be,
      input  d_req_ready, d_rsp_valid, d_rsp_data,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata,
      input  owner, state_vector, err_misaligned
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and load/store.
// One transaction in flight; round-robin on ties; fixed-latency read capture.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | arbitrate, accept one request (valid & ready)
// ISSUE  | drive mem_en with the latched request for one cycle
// WAIT   | count down MEM_LATENCY-1 .. 0, capture mem_rdata at 0
// RESP   | one-cycle rsp_valid pulse to the owner
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 2     // legal range 1..15
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);
   localparam int BE_W = DATA_W / 8;
   localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              last_grant_q;    // 0 = fetch, 1 = data
   logic              owner_q;
   logic              we_q;
   logic              err_q;

   logic              mem_en_q;
   logic              mem_we_q;
   logic [BE_W-1:0]   mem_be_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;

   logic              if_rsp_valid_q;
   logic [DATA_W-1:0] if_rsp_data_q;
   logic              d_rsp_valid_q;
   logic [DATA_W-1:0] d_rsp_data_q;

   logic              if_grant_d;
   logic              d_grant_d;

   // Combinational arbitration; readys are held low while rst is asserted so
   // they drop within the same cycle as an asynchronous abort.
   always_comb begin
      if_grant_d = 1'b0;
      d_grant_d  = 1'b0;
      if (!rst && state_q == S_IDLE) begin
         if (bus.if_req_valid && bus.d_req_valid) begin
            if (last_grant_q) if_grant_d = 1'b1;
            else              d_grant_d  = 1'b1;
         end else if (bus.if_req_valid) begin
            if_grant_d = 1'b1;
         end else if (bus.d_req_valid) begin
            d_grant_d = 1'b1;
         end
      end
   end

   // Transaction FSM with registered memory-port and response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         last_grant_q   <= 1'b1;
         owner_q        <= 1'b0;
         we_q           <= 1'b0;
         err_q          <= 1'b0;
         mem_en_q       <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_be_q       <= '0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         if_rsp_valid_q <= 1'b0;
         if_rsp_data_q  <= '0;
         d_rsp_valid_q  <= 1'b0;
         d_rsp_data_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (d_grant_d) begin
                  owner_q      <= 1'b1;
                  last_grant_q <= 1'b1;
                  we_q         <= bus.d_req_we;
                  mem_en_q     <= 1'b1;
                  mem_we_q     <= bus.d_req_we;
                  mem_be_q     <= bus.d_req_be;
                  mem_addr_q   <= bus.d_req_addr;
                  mem_wdata_q  <= bus.d_req_wdata;
                  state_q      <= S_ISSUE;
               end else if (if_grant_d) begin
                  // Fetches are always aligned word reads.
                  owner_q      <= 1'b0;
                  last_grant_q <= 1'b0;
                  we_q         <= 1'b0;
                  mem_en_q     <= 1'b1;
                  mem_we_q     <= 1'b0;
                  mem_be_q     <= '1;
                  mem_addr_q   <= {bus.if_req_addr[ADDR_W-1:2], 2'b00};
                  mem_wdata_q  <= '0;
                  if (bus.if_req_addr[1:0] != 2'b00) err_q <= 1'b1;
                  state_q      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               mem_en_q    <= 1'b0;
               mem_we_q    <= 1'b0;
               mem_be_q    <= '0;
               mem_addr_q  <= '0;
               mem_wdata_q <= '0;
               cnt_q       <= CNT_LOAD;
               state_q     <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  if (owner_q) begin
                     d_rsp_valid_q <= 1'b1;
                     d_rsp_data_q  <= we_q ? '0 : bus.mem_rdata;
                  end else begin
                     if_rsp_valid_q <= 1'b1;
                     if_rsp_data_q  <= bus.mem_rdata;
                  end
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_RESP: begin
               if_rsp_valid_q <= 1'b0;
               if_rsp_data_q  <= '0;
               d_rsp_valid_q  <= 1'b0;
               d_rsp_data_q   <= '0;
               state_q        <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.if_req_ready   = if_grant_d;
   assign bus.d_req_ready    = d_grant_d;
   assign bus.if_rsp_valid   = if_rsp_valid_q;
   assign bus.if_rsp_data    = if_rsp_data_q;
   assign bus.d_rsp_valid    = d_rsp_valid_q;
   assign bus.d_rsp_data     = d_rsp_data_q;
   assign bus.mem_en         = mem_en_q;
   assign bus.mem_we         = mem_we_q;
   assign bus.mem_be         = mem_be_q;
   assign bus.mem_addr       = mem_addr_q;
   assign bus.mem_wdata      = mem_wdata_q;
   assign bus.owner          = owner_q;
   assign bus.state_vector   = state_q;
   assign bus.err_misaligned = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed requests, scoreboard queues of expected
// responses, and per-instance monitors that pop and compare on rsp_valid.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic exp_err = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2  ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1  ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b15 ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2))  u_l2  (.clk(clk), .rst(rst), .bus(b2));
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1))  u_l1  (.clk(clk), .rst(rst), .bus(b1));
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(15)) u_l15 (.clk(clk), .rst(rst), .bus(b15));

   typedef struct {
      logic        own;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t q2[$];
   exp_t q1[$];
   exp_t q15[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void cmp_rsp(input string nm, input exp_t e,
                                   input logic ifv, input logic [31:0] ifd,
                                   input logic dv, input logic [31:0] dd);
      chk({nm, " rsp_cycle"}, cyc, e.cyc);
      chk({nm, " rsp_owner"}, {30'd0, ifv, dv}, e.own ? 32'd1 : 32'd2);
      chk({nm, " rsp_data"}, dv ? dd : ifd, e.data);
      chk({nm, " nonowner_data"}, dv ? ifd : dd, 32'd0);
   endfunction

   // Memory models: read data is correct only in the exact sample cycle.
   int          en2 = -100, en1 = -100, en15 = -100;
   logic [31:0] ea2 = '0, ea1 = '0, ea15 = '0;
   always @(posedge clk) begin
      if (b2.mem_en)  begin en2  <= cyc; ea2  <= b2.mem_addr;  end
      if (b1.mem_en)  begin en1  <= cyc; ea1  <= b1.mem_addr;  end
      if (b15.mem_en) begin en15 <= cyc; ea15 <= b15.mem_addr; end
   end
   assign b2.mem_rdata  = (cyc == en2 + 2)   ? mem_word(ea2)  : (32'hBAD00000 ^ 32'(cyc));
   assign b1.mem_rdata  = (cyc == en1 + 1)   ? mem_word(ea1)  : (32'hBAD00000 ^ 32'(cyc));
   assign b15.mem_rdata = (cyc == en15 + 15) ? mem_word(ea15) : (32'hBAD00000 ^ 32'(cyc));

   // Monitors
   always @(negedge clk) begin
      exp_t e;
      if (b2.if_rsp_valid || b2.d_rsp_valid) begin
         if (q2.size() == 0) chk("L2 unexpected_rsp", {30'd0, b2.if_rsp_valid, b2.d_rsp_valid}, 32'd0);
         else begin e = q2.pop_front(); cmp_rsp("L2", e, b2.if_rsp_valid, b2.if_rsp_data, b2.d_rsp_valid, b2.d_rsp_data); end
      end
      if (b1.if_rsp_valid || b1.d_rsp_valid) begin
         if (q1.size() == 0) chk("L1 unexpected_rsp", {30'd0, b1.if_rsp_valid, b1.d_rsp_valid}, 32'd0);
         else begin e = q1.pop_front(); cmp_rsp("L1", e, b1.if_rsp_valid, b1.if_rsp_data, b1.d_rsp_valid, b1.d_rsp_data); end
      end
      if (b15.if_rsp_valid || b15.d_rsp_valid) begin
         if (q15.size() == 0) chk("L15 unexpected_rsp", {30'd0, b15.if_rsp_valid, b15.d_rsp_valid}, 32'd0);
         else begin e = q15.pop_front(); cmp_rsp("L15", e, b15.if_rsp_valid, b15.if_rsp_data, b15.d_rsp_valid, b15.d_rsp_data); end
      end
      chk("ready_outside_idle", {31'd0, (b2.state_vector != 2'd0) && (b2.if_req_ready || b2.d_req_ready)}, 32'd0);
      chk("mem_nonzero_without_en", {31'd0, !b2.mem_en && (b2.mem_we || b2.mem_be != 4'd0 ||
                                      b2.mem_addr != 32'd0 || b2.mem_wdata != 32'd0)}, 32'd0);
   end

   // One request on the L2 instance; checks the issue cycle and optionally
   // queues the expected response.
   task automatic req(input logic is_d, input logic [31:0] addr, input logic we,
                      input logic [31:0] wd, input logic [3:0] be, input logic push,
                      output int acc);
      int          n;
      logic [31:0] ma;
      n   = 0;
      acc = -1;
      ma  = is_d ? addr : {addr[31:2], 2'b00};
      @(negedge clk);
      if (is_d) begin
         b2.d_req_valid = 1'b1; b2.d_req_addr = addr; b2.d_req_we = we;
         b2.d_req_wdata = wd;   b2.d_req_be = be;
      end else begin
         b2.if_req_valid = 1'b1; b2.if_req_addr = addr;
      end
      #1;
      while (!(is_d ? b2.d_req_ready : b2.if_req_ready) && n < 50) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 50) begin
         chk("accept_timeout", 32'd1, 32'd0);
         b2.d_req_valid = 1'b0; b2.if_req_valid = 1'b0;
         return;
      end
      acc = cyc;
      if (!is_d && addr[1:0] != 2'b00) exp_err = 1'b1;
      if (push) q2.push_back('{own: is_d, data: (is_d && we) ? 32'd0 : mem_word(ma), cyc: acc + 4});
      @(negedge clk);
      b2.d_req_valid = 1'b0; b2.if_req_valid = 1'b0;
      chk("issue mem_en",    {31'd0, b2.mem_en}, 32'd1);
      chk("issue mem_we",    {31'd0, b2.mem_we}, {31'd0, is_d & we});
      chk("issue mem_addr",  b2.mem_addr, ma);
      chk("issue mem_be",    {28'd0, b2.mem_be}, is_d ? {28'd0, be} : 32'hF);
      chk("issue mem_wdata", b2.mem_wdata, is_d ? wd : 32'd0);
      chk("issue owner",     {31'd0, b2.owner}, {31'd0, is_d});
      chk("err_misaligned",  {31'd0, b2.err_misaligned}, {31'd0, exp_err});
      @(negedge clk);
      chk("mem_en one_cycle", {31'd0, b2.mem_en}, 32'd0);
   endtask

   initial begin
      int acc;
      int c0;
      int nacc;
      int accs[4];
      logic gnt[4];

      b2.if_req_valid = 1'b0; b2.if_req_addr = '0;
      b2.d_req_valid = 1'b0; b2.d_req_we = 1'b0; b2.d_req_addr = '0; b2.d_req_wdata = '0; b2.d_req_be = '0;
      b1.if_req_valid = 1'b0; b1.if_req_addr = '0;
      b1.d_req_valid = 1'b0; b1.d_req_we = 1'b0; b1.d_req_addr = '0; b1.d_req_wdata = '0; b1.d_req_be = '0;
      b15.if_req_valid = 1'b0; b15.if_req_addr = '0;
      b15.d_req_valid = 1'b0; b15.d_req_we = 1'b0; b15.d_req_addr = '0; b15.d_req_wdata = '0; b15.d_req_be = '0;

      // Reset values, with a request pending during reset
      repeat (2) @(negedge clk);
      b2.if_req_valid = 1'b1; b2.d_req_valid = 1'b1;
      #1;
      chk("rst if_ready", {31'd0, b2.if_req_ready}, 32'd0);
      chk("rst d_ready",  {31'd0, b2.d_req_ready}, 32'd0);
      chk("rst state",    {30'd0, b2.state_vector}, 32'd0);
      chk("rst owner",    {31'd0, b2.owner}, 32'd0);
      chk("rst err",      {31'd0, b2.err_misaligned}, 32'd0);
      chk("rst mem_en",   {31'd0, b2.mem_en}, 32'd0);
      b2.if_req_valid = 1'b0; b2.d_req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Round-robin with both valids held
      @(negedge clk);
      b2.if_req_valid = 1'b1; b2.if_req_addr = 32'h300;
      b2.d_req_valid = 1'b1;  b2.d_req_addr = 32'h400; b2.d_req_we = 1'b0;
      b2.d_req_be = 4'hF;     b2.d_req_wdata = 32'h0;
      c0 = cyc;
      nacc = 0;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (b2.if_req_ready && b2.d_req_ready) chk("rr both_ready", 32'd1, 32'd0);
         if (b2.if_req_ready || b2.d_req_ready) begin
            if (nacc < 4) begin accs[nacc] = cyc - c0; gnt[nacc] = b2.d_req_ready; end
            q2.push_back('{own: b2.d_req_ready,
                           data: mem_word(b2.d_req_ready ? 32'h400 : 32'h300), cyc: cyc + 4});
            nacc++;
         end
         @(negedge clk);
      end
      b2.if_req_valid = 1'b0; b2.d_req_valid = 1'b0;
      chk("rr accept_count", nacc, 32'd4);
      for (int i = 0; i < 4 && i < nacc; i++) begin
         chk("rr accept_cycle", accs[i], 5 * i);
         chk("rr grant_order", {31'd0, gnt[i]}, {31'd0, i[0]});
      end

      // Single fetch, data write, data read
      req(1'b0, 32'h100, 1'b0, 32'h0, 4'h0, 1'b1, acc);
      req(1'b1, 32'h200, 1'b1, 32'h12345678, 4'b0011, 1'b1, acc);
      req(1'b1, 32'h208, 1'b0, 32'hFFFFFFFF, 4'b1100, 1'b1, acc);

      // Misaligned fetch, then an aligned one; the flag stays set
      req(1'b0, 32'h102, 1'b0, 32'h0, 4'h0, 1'b1, acc);
      req(1'b0, 32'h104, 1'b0, 32'h0, 4'h0, 1'b1, acc);
      repeat (4) @(negedge clk);
      chk("err sticky", {31'd0, b2.err_misaligned}, 32'd1);

      // Reset while in WAIT; the aborted fetch must never respond
      req(1'b0, 32'h180, 1'b0, 32'h0, 4'h0, 1'b0, acc);
      chk("pre_abort state", {30'd0, b2.state_vector}, 32'd2);
      b2.d_req_valid = 1'b1; b2.d_req_addr = 32'h500; b2.d_req_we = 1'b0;
      rst = 1'b1;
      exp_err = 1'b0;
      #1;
      chk("abort mem_en",   {31'd0, b2.mem_en}, 32'd0);
      chk("abort rsp",      {30'd0, b2.if_rsp_valid, b2.d_rsp_valid}, 32'd0);
      chk("abort readys",   {30'd0, b2.if_req_ready, b2.d_req_ready}, 32'd0);
      chk("abort state",    {30'd0, b2.state_vector}, 32'd0);
      chk("abort err",      {31'd0, b2.err_misaligned}, 32'd0);
      repeat (2) @(negedge clk);
      b2.d_req_valid = 1'b0;
      rst = 1'b0;
      repeat (8) @(negedge clk);
      req(1'b0, 32'h140, 1'b0, 32'h0, 4'h0, 1'b1, acc);

      // Latency extremes on the L1 and L15 instances
      @(negedge clk);
      b1.if_req_valid = 1'b1;  b1.if_req_addr = 32'h100;
      b15.if_req_valid = 1'b1; b15.if_req_addr = 32'h2C0;
      #1;
      chk("L1 ready",  {31'd0, b1.if_req_ready}, 32'd1);
      chk("L15 ready", {31'd0, b15.if_req_ready}, 32'd1);
      q1.push_back('{own: 1'b0, data: 32'hDEADBEEF, cyc: cyc + 3});
      q15.push_back('{own: 1'b0, data: mem_word(32'h2C0), cyc: cyc + 17});
      @(negedge clk);
      b1.if_req_valid = 1'b0; b15.if_req_valid = 1'b0;
      repeat (22) @(negedge clk);

      chk("q2 drained",  q2.size(),  32'd0);
      chk("q1 drained",  q1.size(),  32'd0);
      chk("q15 drained", q15.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
